// File: rtl/paula_audio_pkg.sv
// Shared constants and slot formatting for the Paula audio I2S transmitter.
package paula_audio_pkg;

  localparam int unsigned AUDIO_SUM_W    = 15;
  localparam int unsigned I2S_WORD_W     = 16;
  localparam int unsigned I2S_FRAME_BITS = 32;
  localparam int unsigned LRCK_LO        = 15;
  localparam int unsigned LRCK_HI        = 30;

  // Left-justify a mixer sum into a 16-bit I2S slot; sign bit stays the MSB.
  function automatic logic [I2S_WORD_W-1:0] to_slot(input logic [AUDIO_SUM_W-1:0] sum);
    return {sum, 1'b0};
  endfunction

endpackage

// File: rtl/paula_audio_i2s_tx.sv
// Philips I2S transmitter for the Paula stereo mixer sums; both channels are
// captured in one clk cycle at each frame load so every frame is coherent.
module paula_audio_i2s_tx
  import paula_audio_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AUDIO_SUM_W-1:0] ldatasum,
  input  logic [AUDIO_SUM_W-1:0] rdatasum,
  input  logic                   mute,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata,
  output logic                   frame_stb
);

  logic [7:0]                div_q, div_d;
  logic                      bclk_q, bclk_d;
  logic                      lrck_q, lrck_d;
  logic                      stb_q, stb_d;
  logic [4:0]                bit_q, bit_d;
  logic [I2S_FRAME_BITS-1:0] shift_q, shift_d;
  logic                      tick, fall;

  assign tick = (div_q == 8'(SCLK_DIV - 1));
  assign fall = tick & bclk_q;

  always_comb begin
    div_d   = tick ? 8'd0 : div_q + 8'd1;
    bclk_d  = tick ? ~bclk_q : bclk_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    lrck_d  = lrck_q;
    stb_d   = 1'b0;
    if (fall) begin
      bit_d = bit_q + 5'd1;
      if (bit_q == 5'd31) begin
        shift_d = mute ? '0 : {to_slot(ldatasum), to_slot(rdatasum)};
        stb_d   = 1'b1;
      end else begin
        shift_d = {shift_q[I2S_FRAME_BITS-2:0], 1'b0};
      end
      // Word select leads the data by one bit, as Philips I2S requires.
      lrck_d = (bit_d >= 5'(LRCK_LO)) && (bit_d <= 5'(LRCK_HI));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      stb_q   <= 1'b0;
      bit_q   <= 5'd31;
      shift_q <= '0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      lrck_q  <= lrck_d;
      stb_q   <= stb_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = shift_q[I2S_FRAME_BITS-1];
  assign frame_stb = stb_q;

endmodule

// File: tb/tb_paula_audio_i2s_tx.sv
// Scoreboard bench for paula_audio_i2s_tx: stimulus queues expected frames, a
// monitor deserialises the I2S stream on BCLK rises and checks timing.
module tb_paula_audio_i2s_tx;

  localparam int unsigned Div   = 9;
  localparam int          Frame = 64 * Div;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] ldatasum, rdatasum;
  logic        mute;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, frame_stb;

  paula_audio_i2s_tx #(.SCLK_DIV(Div)) dut (
    .clk      (clk),
    .reset    (reset),
    .ldatasum (ldatasum),
    .rdatasum (rdatasum),
    .mute     (mute),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_sdata(i2s_sdata),
    .frame_stb(frame_stb)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_stb = 0;
  int stb_cnt = 0;
  int seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic end_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
    end_run();
  endtask

  // Monitor: cycle counter, timing checks and frame deserialisation.
  initial begin
    logic        rs, prev_bclk, capturing, after_reset, need_rise;
    logic [31:0] word, lr;
    int          idx;
    prev_bclk = 1'b0; capturing = 1'b0; after_reset = 1'b1; need_rise = 1'b1;
    word = '0; lr = '0; idx = 0;
    forever begin
      @(posedge clk);
      rs = reset;
      #1;
      if (rs) begin
        cyc = 0; capturing = 1'b0; after_reset = 1'b1; need_rise = 1'b1; prev_bclk = 1'b0;
      end else begin
        cyc++;
        if (need_rise && i2s_bclk && !prev_bclk) begin
          check("first_bclk_rise_cycle", cyc, 9);
          need_rise = 1'b0;
        end
        if (frame_stb) begin
          if (after_reset) check("first_load_cycle", cyc, 2 * Div);
          else             check("frame_period", cyc - last_stb, Frame);
          after_reset = 1'b0;
          last_stb = cyc;
          stb_cnt++;
          capturing = 1'b1;
          idx = 0;
        end else if (capturing && i2s_bclk && !prev_bclk) begin
          word[31-idx] = i2s_sdata;
          lr[31-idx]   = i2s_lrck;
          idx++;
          if (idx == 32) begin
            capturing = 1'b0;
            if (exp_q.size() == 0) begin
              n_total++;
              $display("FAIL frame_data: got %h, expected nothing queued", word);
            end else begin
              check("frame_data", word, exp_q.pop_front());
              check("lrck_pattern", lr, 32'h0001_FFFE);
            end
          end
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  task automatic wait_stb();
    int n = 0;
    seen++;
    while (stb_cnt < seen) begin
      @(negedge clk);
      if (++n > 2 * Frame) timeout("frame_stb_wait");
    end
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target) begin
      @(negedge clk);
      if (++n > 2 * Frame) timeout("cycle_wait");
    end
  endtask

  function automatic logic [14:0] churn(input int n);
    return 15'(n * 37 + 11);
  endfunction

  initial begin
    int c;
    reset = 1'b1; mute = 1'b0; ldatasum = 15'h4001; rdatasum = 15'h3FFE;
    repeat (3) @(negedge clk);
    exp_q.push_back({16'h8002, 16'h7FFC});
    reset = 1'b0;
    wait_stb();

    ldatasum = 15'h7FFF; rdatasum = 15'h4000;
    exp_q.push_back({16'hFFFE, 16'h8000});
    wait_stb();

    ldatasum = 15'h1234; rdatasum = 15'h0ABC;
    exp_q.push_back({16'h2468, 16'h1578});
    wait_stb();
    // Mute in the middle of a frame must not touch the frame in flight.
    repeat (100) @(negedge clk);
    mute = 1'b1;
    repeat (50) @(negedge clk);
    mute = 1'b0;

    // Mute held for exactly the load edge zeroes the whole frame.
    ldatasum = 15'h2AAA; rdatasum = 15'h5555;
    exp_q.push_back(32'h0);
    wait_cyc(last_stb + Frame - 1);
    mute = 1'b1;
    @(negedge clk);
    mute = 1'b0;
    wait_stb();

    // Left input changes every clk; only the value at the load edge counts.
    c = last_stb;
    rdatasum = 15'h0001;
    exp_q.push_back({churn(c + Frame - 1), 1'b0, 16'h0002});
    while (cyc < c + Frame + 4) begin
      @(negedge clk);
      ldatasum = churn(cyc);
    end
    wait_stb();

    ldatasum = 15'h0F0F; rdatasum = 15'h7070;
    exp_q.push_back({16'h1E1E, 16'hE0E0});
    wait_stb();
    // Reset at bit_cnt 20; the aborted frame's entry stays queued for the fresh load.
    wait_cyc(last_stb + 20 * 2 * Div + 5);
    reset = 1'b1;
    @(negedge clk);
    check("reset_bclk", {31'b0, i2s_bclk}, 32'd0);
    check("reset_lrck", {31'b0, i2s_lrck}, 32'd0);
    check("reset_sdata", {31'b0, i2s_sdata}, 32'd0);
    check("reset_stb", {31'b0, frame_stb}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_stb();

    begin
      int n = 0;
      while (exp_q.size() != 0) begin
        @(negedge clk);
        if (++n > 2 * Frame) timeout("scoreboard_drain");
      end
    end
    repeat (20) @(negedge clk);
    end_run();
  end

endmodule
